serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 93 +++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// one operand bit per clock, LSB first; results are published once per operation.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             c;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             s;
  logic             co;

  // The single full-adder cell works on the LSB of the operand shifters.
  always_comb begin
    s  = areg[0] ^ breg[0] ^ c;
    co = (areg[0] & breg[0]) | ((areg[0] ^ breg[0]) & c);
  end

  // Sum bits shift into the top of areg as operand bits leave the bottom,
  // so after WIDTH steps areg would hold the full result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      c        <= 1'b0;
      areg     <= '0;
      breg     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            c     <= cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          areg <= {s, areg[WIDTH-1:1]};
          breg <= {1'b0, breg[WIDTH-1:1]};
          c    <= co;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= {s, areg[WIDTH-1:1]};
            carry    <= co;
            overflow <= c ^ co;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (directed, protocol, random,
// reset) and WIDTH=2 (exhaustive), against a plain-arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ov8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, carry2, ov2;
  logic [1:0] sum2;

  int         vectors = 0;
  int         miscompares = 0;
  int         done2_cnt = 0;
  int         sel = 8;

  logic [63:0] last_s8 = '0, last_s2 = '0;
  logic        last_c8 = 1'b0, last_c2 = 1'b0, last_v8 = 1'b0, last_v2 = 1'b0;

  logic        o_busy, o_done, o_carry, o_ov;
  logic [63:0] o_sum;

  assign o_busy  = (sel == 2) ? busy2  : busy8;
  assign o_done  = (sel == 2) ? done2  : done8;
  assign o_carry = (sel == 2) ? carry2 : carry8;
  assign o_ov    = (sel == 2) ? ov2    : ov8;
  assign o_sum   = (sel == 2) ? 64'(sum2) : 64'(sum8);

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ov8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ov2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done2 === 1'b1) done2_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operand values.
  function automatic void model(input int w, input longint av, input longint bv,
                                input bit ci, input bit sb, output logic [63:0] s,
                                output logic c, output logic ov);
    longint m, half, sa, sbv, r, sr;
    m    = longint'(1) << w;
    half = m >> 1;
    sa   = (av >= half) ? av - m : av;
    sbv  = (bv >= half) ? bv - m : bv;
    if (!sb) begin
      r  = av + bv + longint'(ci);
      c  = (r >= m);
      sr = sa + sbv + longint'(ci);
    end else begin
      r  = av - bv - longint'(ci);
      c  = (r >= 0);
      sr = sa - sbv - longint'(ci);
    end
    s  = 64'(r & (m - 1));
    ov = (sr < -half) || (sr > half - 1);
  endfunction

  task automatic drive(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, input logic st);
    if (w == 2) begin
      a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci; sub2 = sb; start2 = st;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; sub8 = sb; start8 = st;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle.
  task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, input string tag);
    logic [63:0] es, ls;
    logic        ec, ev, lc, lv;
    sel = w;
    model(w, longint'(av), longint'(bv), ci, sb, es, ec, ev);
    ls = (w == 2) ? last_s2 : last_s8;
    lc = (w == 2) ? last_c2 : last_c8;
    lv = (w == 2) ? last_v2 : last_v8;
    drive(w, av, bv, ci, sb, 1'b1);
    @(posedge clk); #1;
    drive(w, 64'($urandom) << 32 | 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk({tag, ".busy_accept"}, 64'(o_busy), 64'(1));
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      if (k < w) begin
        chk({tag, ".busy_run"}, 64'(o_busy), 64'(1));
        chk({tag, ".done_run"}, 64'(o_done), 64'(0));
        chk({tag, ".sum_hold"}, o_sum, ls);
        chk({tag, ".cv_hold"}, 64'({o_carry, o_ov}), 64'({lc, lv}));
      end else begin
        chk({tag, ".done"}, 64'(o_done), 64'(1));
        chk({tag, ".busy_end"}, 64'(o_busy), 64'(0));
        chk({tag, ".sum"}, o_sum, es);
        chk({tag, ".carry"}, 64'(o_carry), 64'(ec));
        chk({tag, ".overflow"}, 64'(o_ov), 64'(ev));
      end
    end
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(o_done), 64'(0));
    if (w == 2) begin last_s2 = es; last_c2 = ec; last_v2 = ev; end
    else begin last_s8 = es; last_c8 = ec; last_v8 = ev; end
  endtask

  initial begin
    logic [63:0] es;
    logic        ec, ev;

    repeat (2) @(posedge clk);
    #1;
    sel = 8;
    chk("reset.busy8", 64'(busy8), 64'(0));
    chk("reset.done8", 64'(done8), 64'(0));
    chk("reset.out8", {55'b0, carry8, ov8, sum8}, 64'(0));
    chk("reset.out2", {59'b0, busy2, done2, carry2, ov2, sum2}, 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8, 64'h0F, 64'h01, 1'b0, 1'b0, "add_0f_01");
    do_op(8, 64'hFF, 64'h01, 1'b0, 1'b0, "wrap_ff_01");
    do_op(8, 64'h7F, 64'h01, 1'b0, 1'b0, "sovf_7f_01");
    do_op(8, 64'h05, 64'h07, 1'b0, 1'b1, "sub_05_07");
    do_op(8, 64'h80, 64'h01, 1'b0, 1'b1, "sub_80_01");
    do_op(8, 64'h05, 64'h02, 1'b1, 1'b1, "subb_05_02");
    do_op(8, 64'hFF, 64'hFF, 1'b1, 1'b0, "add_ff_ff_c");

    // start held high: one operation every WIDTH+2 cycles
    model(8, 64'h3C, 64'h5A, 1'b1, 1'b0, es, ec, ev);
    sel = 8;
    drive(8, 64'h3C, 64'h5A, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      chk("held.busy", 64'(busy8), 64'((cyc % 10) < 8));
      chk("held.done", 64'(done8), 64'((cyc % 10) == 8));
      if ((cyc % 10) == 8) chk("held.sum", 64'({carry8, ov8, sum8}), 64'({ec, ev, es[7:0]}));
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    last_s8 = es; last_c8 = ec; last_v8 = ev;

    for (int i = 0; i < 20; i++)
      do_op(8, 64'($urandom_range(255)), 64'($urandom_range(255)),
            1'($urandom), 1'($urandom), "rand8");

    do_op(8, 64'h05, 64'h02, 1'b1, 1'b1, "pre_reset");
    // reset in the middle of bit 4 of 0xAA+0x55
    drive(8, 64'hAA, 64'h55, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 64'(busy8), 64'(0));
    chk("rst_mid.done", 64'(done8), 64'(0));
    chk("rst_mid.sum", 64'(sum8), 64'(0));
    chk("rst_mid.cv", 64'({carry8, ov8}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("rst_mid.no_done", 64'({busy8, done8}), 64'(0));
    end
    last_s8 = '0; last_c8 = 1'b0; last_v8 = 1'b0;
    last_s2 = '0; last_c2 = 1'b0; last_v2 = 1'b0;
    do_op(8, 64'hAA, 64'h55, 1'b0, 1'b0, "post_reset");

    done2_cnt = 0;
    for (int unsigned v = 0; v < 64; v++)
      do_op(2, 64'(v[5:4]), 64'(v[3:2]), v[1], v[0], "exh2");
    @(posedge clk); #1;
    chk("exh2.done_count", 64'(done2_cnt), 64'(64));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
